// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types and sizing for the common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int CDB_SIZE          = 5;
    localparam int CDB_ARB_BUF_DEPTH = 2;
    localparam int ROB_IDX_W         = 5;

    typedef enum logic [2:0] {
        CDB_ALU = 3'd0,
        CDB_MUL = 3'd1,
        CDB_DIV = 3'd2,
        CDB_LS  = 3'd3,
        CDB_BR  = 3'd4
    } CDB_ind_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] ROB_entry;
        logic [31:0]          rd_data;
    } CDB_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: circular buffer with head/tail pointers and an
// occupancy count; clr empties it in one edge.
module cdb_src_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[tail] <= din;
    end

    assign dout = mem[head];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        clr || !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        clr || !(pop && count == '0));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter putting at most one functional-unit result per cycle on
// the common data bus; each unit has a small FIFO, empty FIFOs are bypassed.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = CDB_SIZE,
    parameter int BUF_DEPTH = CDB_ARB_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NUM_SRC-1:0]    fu_valid,
    input  CDB_t [NUM_SRC-1:0]    fu_pkt,
    output logic [NUM_SRC-1:0]    fu_ready,
    output CDB_t                  cdb_out
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PKT_W = $bits(CDB_t);

    logic [CNT_W-1:0]   count [NUM_SRC];
    CDB_t               head [NUM_SRC];
    CDB_t               cand_pkt [NUM_SRC];
    logic [NUM_SRC-1:0] has_head;
    logic [NUM_SRC-1:0] xfer;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [PTR_W:0]     idx;
    CDB_t               gnt_pkt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // Ready depends only on stored occupancy, never on this cycle's grant.
        assign fu_ready[i] = rst_n && (count[i] < CNT_W'(BUF_DEPTH));
        assign has_head[i] = (count[i] != '0);
        assign xfer[i]     = fu_valid[i] && fu_ready[i];
        assign cand[i]     = has_head[i] || xfer[i];
        assign cand_pkt[i] = has_head[i] ? head[i] : fu_pkt[i];
        assign pop[i]      = gnt_found && (gnt_idx == PTR_W'(i)) && has_head[i];
        assign push[i]     = xfer[i] && !(gnt_found && (gnt_idx == PTR_W'(i)) && !has_head[i]);

        cdb_src_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush),
            .push  (push[i]),
            .din   (fu_pkt[i]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .count (count[i])
        );
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_SRC)) idx = idx - (PTR_W+1)'(NUM_SRC);
            if (!gnt_found && cand[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PTR_W-1:0];
            end
        end
        gnt_pkt       = cand_pkt[gnt_idx];
        gnt_pkt.valid = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            cdb_out <= '0;
        end else if (flush) begin
            cdb_out.valid <= 1'b0;
        end else if (gnt_found) begin
            cdb_out <= gnt_pkt;
            rr_ptr  <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
            cdb_out.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int BD = 2;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic [N-1:0]   fu_valid;
    CDB_t [N-1:0]   fu_pkt;
    logic [N-1:0]   fu_ready;
    CDB_t           cdb_out;

    cdb_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_pkt   (fu_pkt),
        .fu_ready (fu_ready),
        .cdb_out  (cdb_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    CDB_t mq [N][$];
    int   m_rr = 0;
    logic exp_v = 1'b0;
    CDB_t exp_pkt;

    typedef struct {
        logic [4:0]  valid;
        logic [4:0]  rob_base;
        logic [31:0] data_base;
        logic [4:0]  exp_ready;
        logic        exp_v;
        logic [4:0]  exp_rob;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr  = 0;
        exp_v = 1'b0;
    endtask

    // Accepted packets join their source queue, then the first non-empty
    // queue from the round-robin pointer is served.
    task automatic model_step(input logic [N-1:0] v, input logic fl);
        int idx;
        bit found;
        found = 0;
        if (fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < N; i++)
                if (v[i] && mq[i].size() < BD) mq[i].push_back(fu_pkt[i]);
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && mq[idx].size() > 0) begin
                    found   = 1;
                    exp_pkt = mq[idx].pop_front();
                    m_rr    = (idx + 1) % N;
                end
            end
        end
        exp_v = found;
    endtask

    task automatic step(input logic [N-1:0] v, input logic fl);
        logic [N-1:0] mr;
        fu_valid = v;
        flush    = fl;
        #1;
        for (int i = 0; i < N; i++) mr[i] = (mq[i].size() < BD);
        chk("fu_ready", fu_ready, mr);
        model_step(v, fl);
        @(posedge clk); #1;
        chk("cdb_valid", cdb_out.valid, exp_v);
        if (exp_v) begin
            chk("cdb_rob", cdb_out.ROB_entry, exp_pkt.ROB_entry);
            chk("cdb_data", cdb_out.rd_data, exp_pkt.rd_data);
        end
    endtask

    task automatic rand_pkts();
        for (int i = 0; i < N; i++) begin
            fu_pkt[i].valid     = 1'($urandom);
            fu_pkt[i].ROB_entry = 5'($urandom);
            fu_pkt[i].rd_data   = $urandom;
        end
    endtask

    task automatic do_reset();
        fu_valid = '0;
        flush    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cdb_valid", cdb_out.valid, 1'b0);
        chk("rst_fu_ready", fu_ready, 5'b00000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", fu_ready, 5'b11111);
        chk("post_rst_cdb", 64'(cdb_out), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [4:0] mul_rob;
    logic [4:0] div_rob;
    bit         r1;
    bit         r2;

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        fu_pkt   = '0;

        vec[0]  = '{5'b00001, 5'd3,  32'h1234, 5'b11111, 1'b1, 5'd3,  32'h1234};
        vec[1]  = '{5'b10000, 5'd10, 32'h0050, 5'b11111, 1'b1, 5'd14, 32'h0054};
        vec[2]  = '{5'b11111, 5'd0,  32'h0100, 5'b11111, 1'b1, 5'd0,  32'h0100};
        vec[3]  = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd1,  32'h0101};
        vec[4]  = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd2,  32'h0102};
        vec[5]  = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd3,  32'h0103};
        vec[6]  = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd4,  32'h0104};
        vec[7]  = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b0, 5'd0,  32'h0000};
        vec[8]  = '{5'b01000, 5'd20, 32'h0200, 5'b11111, 1'b1, 5'd23, 32'h0203};
        vec[9]  = '{5'b10001, 5'd24, 32'h0300, 5'b11111, 1'b1, 5'd28, 32'h0304};
        vec[10] = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd24, 32'h0300};
        vec[11] = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b0, 5'd0,  32'h0000};
        vec[12] = '{5'b00011, 5'd16, 32'h0400, 5'b11111, 1'b1, 5'd17, 32'h0401};
        vec[13] = '{5'b00000, 5'd0,  32'h0000, 5'b11111, 1'b1, 5'd16, 32'h0400};

        #1;
        chk("init_rst_ready", fu_ready, 5'b00000);
        chk("init_rst_cdb", 64'(cdb_out), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_ready", fu_ready, 5'b11111);
        @(posedge clk); #1;

        // Directed table: bypass latency, all-five burst, rr wrap from 4.
        for (int n = 0; n < NV; n++) begin
            for (int i = 0; i < N; i++) begin
                fu_pkt[i].valid     = 1'b0;
                fu_pkt[i].ROB_entry = vec[n].rob_base + 5'(i);
                fu_pkt[i].rd_data   = vec[n].data_base + 32'(i);
            end
            fu_valid = vec[n].valid;
            flush    = 1'b0;
            #1;
            chk("tbl_ready", fu_ready, vec[n].exp_ready);
            model_step(vec[n].valid, 1'b0);
            @(posedge clk); #1;
            chk("tbl_valid", cdb_out.valid, vec[n].exp_v);
            if (vec[n].exp_v) begin
                chk("tbl_rob", cdb_out.ROB_entry, vec[n].exp_rob);
                chk("tbl_data", cdb_out.rd_data, vec[n].exp_data);
            end
        end

        // mul and div streaming every cycle; source advances only on transfer.
        mul_rob = 5'd0;
        div_rob = 5'd16;
        for (int c = 0; c < 12; c++) begin
            r1 = (mq[1].size() < BD);
            r2 = (mq[2].size() < BD);
            fu_pkt[1] = '{1'b0, mul_rob, $urandom};
            fu_pkt[2] = '{1'b0, div_rob, $urandom};
            step(5'b00110, 1'b0);
            if (r1) mul_rob = mul_rob + 5'd1;
            if (r2) div_rob = div_rob + 5'd1;
        end
        repeat (5) step(5'b00000, 1'b0);

        // Flush with three buffered entries and a br packet in the same cycle.
        rand_pkts();
        step(5'b00111, 1'b0);
        rand_pkts();
        step(5'b11000, 1'b0);
        fu_pkt[4] = '{1'b1, 5'd31, 32'hDEAD_BEEF};
        step(5'b10000, 1'b1);
        chk("flush_cdb_valid", cdb_out.valid, 1'b0);
        repeat (3) step(5'b00000, 1'b0);

        for (int c = 0; c < 400; c++) begin
            rand_pkts();
            step(N'($urandom), ($urandom_range(0, 19) == 0));
        end

        // Reset in the middle of traffic with three entries buffered.
        step(5'b00000, 1'b1);
        rand_pkts();
        step(5'b00111, 1'b0);
        rand_pkts();
        step(5'b11000, 1'b0);
        do_reset();
        repeat (3) step(5'b00000, 1'b0);
        rand_pkts();
        step(5'b10001, 1'b0);
        repeat (2) step(5'b00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
